// File: rtl/pcileech_rmii_rx.sv
// RMII receive framer, 100 Mbit/s, one dibit per 50 MHz clock.
// Removes the preamble and SFD. Assembles dibits (LSB first) into bytes.
// Checks the Ethernet FCS residue and reports framing faults per frame.
// Ports:
//   clk, rst_n                      RMII reference clock, async active-low reset
//   eth_crs_dv, eth_rx_data[1:0]    RMII receive pins (data bit 0 is earlier)
//   eth_rx_err                      PHY receive error
//   rx_data[7:0], rx_valid, rx_sof  byte stream; rx_sof marks the first byte
//   rx_eof, rx_len[10:0],           end-of-frame strobe with length,
//   rx_fcs_ok, rx_err               FCS status and fault status
//   stat_frames_ok/bad[15:0]        saturating frame counters
module pcileech_rmii_rx #(
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eth_crs_dv,
  input  logic [1:0]  eth_rx_data,
  input  logic        eth_rx_err,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [10:0] rx_len,
  output logic        rx_fcs_ok,
  output logic        rx_err,
  output logic [15:0] stat_frames_ok,
  output logic [15:0] stat_frames_bad
);

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);

  typedef enum logic [1:0] {DROP, IDLE, PREAMBLE, DATA} state_t;

  state_t      state_q, state_d;
  // s_* : registered pins; p_* : the sample being decided; h_dv_q : the one before it
  logic        s_dv_q, s_er_q, p_dv_q, p_er_q, h_dv_q;
  logic [1:0]  s_d_q, p_d_q;
  logic [5:0]  sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic [10:0] olen_q, olen_d;
  logic        fok_q, fok_d, oerr_q, oerr_d;
  logic [15:0] ok_q, ok_d, bad_q, bad_d;
  logic        commit, eoc;
  logic [7:0]  byte_w;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r >> 1) ^ (((r[0] ^ b[i]) != 1'b0) ? 32'hEDB88320 : '0);
    return r;
  endfunction

  // A low sample is committed only when it sits between two high samples
  // (mid-frame CRS_DV toggling). After end of carrier, the last low sample
  // before the next frame is not treated as data.
  assign commit = p_dv_q | (s_dv_q & h_dv_q);
  assign eoc    = ~p_dv_q & ~h_dv_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    crc_d   = crc_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    olen_d  = olen_q;
    fok_d   = fok_q;
    oerr_d  = oerr_q;
    ok_d    = ok_q;
    bad_d   = bad_q;
    byte_w  = {p_d_q, sh_q};

    unique case (state_q)
      DROP: begin
        if (eoc) state_d = IDLE;
      end
      IDLE: begin
        if (commit) state_d = (p_d_q == 2'b01) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (eoc) begin
          state_d = IDLE;
        end else if (commit) begin
          if (p_d_q == 2'b11) begin
            state_d = DATA;
            crc_d   = '1;
            len_d   = '0;
            cnt_d   = '0;
            ferr_d  = 1'b0;
          end else if (p_d_q != 2'b01) begin
            state_d = DROP;
          end
        end
      end
      DATA: begin
        if (p_er_q) ferr_d = 1'b1;
        if (eoc) begin
          eof_d   = 1'b1;
          olen_d  = len_q;
          fok_d   = (crc_q == CRC_RESIDUE);
          oerr_d  = ferr_q | p_er_q | (cnt_q != 2'd0) | (len_q < MIN_L);
          state_d = IDLE;
        end else if (commit) begin
          cnt_d = cnt_q + 2'd1;
          sh_d  = {p_d_q, sh_q[5:2]};
          if (cnt_q == 2'd3) begin
            if (len_q == MAX_L) begin
              eof_d   = 1'b1;
              olen_d  = MAX_L;
              fok_d   = (crc_q == CRC_RESIDUE);
              oerr_d  = 1'b1;
              state_d = DROP;
            end else begin
              valid_d = 1'b1;
              data_d  = byte_w;
              sof_d   = (len_q == 11'd0);
              len_d   = len_q + 11'd1;
              crc_d   = crc_byte(crc_q, byte_w);
            end
          end
        end
      end
      default: state_d = DROP;
    endcase

    if (eof_d) begin
      if (!oerr_d && fok_d) begin
        if (ok_q != '1) ok_d = ok_q + 16'd1;
      end else begin
        if (bad_q != '1) bad_d = bad_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Carrier is assumed present after reset so two real low samples are required
      s_dv_q  <= 1'b1;
      p_dv_q  <= 1'b1;
      h_dv_q  <= 1'b1;
      s_er_q  <= 1'b0;
      p_er_q  <= 1'b0;
      s_d_q   <= '0;
      p_d_q   <= '0;
      state_q <= DROP;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      crc_q   <= '1;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      olen_q  <= '0;
      fok_q   <= 1'b0;
      oerr_q  <= 1'b0;
      ok_q    <= '0;
      bad_q   <= '0;
    end else begin
      s_dv_q  <= eth_crs_dv;
      s_d_q   <= eth_rx_data;
      s_er_q  <= eth_rx_err;
      p_dv_q  <= s_dv_q;
      p_d_q   <= s_d_q;
      p_er_q  <= s_er_q;
      h_dv_q  <= p_dv_q;
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      olen_q  <= olen_d;
      fok_q   <= fok_d;
      oerr_q  <= oerr_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  assign rx_data         = data_q;
  assign rx_valid        = valid_q;
  assign rx_sof          = sof_q;
  assign rx_eof          = eof_q;
  assign rx_len          = olen_q;
  assign rx_fcs_ok       = fok_q;
  assign rx_err          = oerr_q;
  assign stat_frames_ok  = ok_q;
  assign stat_frames_bad = bad_q;

endmodule

// File: tb/tb_pcileech_rmii_rx.sv
// Scoreboard bench for pcileech_rmii_rx: the stimulus pushes expected bytes and
// eof records into a queue. A negedge monitor pops and compares each strobe.
module tb_pcileech_rmii_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        eth_crs_dv;
  logic [1:0]  eth_rx_data;
  logic        eth_rx_err;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_fcs_ok, rx_err;
  logic [10:0] rx_len;
  logic [15:0] stat_frames_ok, stat_frames_bad;

  always #10 clk = ~clk;

  pcileech_rmii_rx #(.MAX_LEN(1522), .MIN_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .eth_crs_dv(eth_crs_dv), .eth_rx_data(eth_rx_data),
    .eth_rx_err(eth_rx_err), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .rx_len(rx_len), .rx_fcs_ok(rx_fcs_ok), .rx_err(rx_err),
    .stat_frames_ok(stat_frames_ok), .stat_frames_bad(stat_frames_bad)
  );

  typedef struct {
    bit          is_eof;
    logic [7:0]  data;
    bit          sof;
    logic [10:0] len;
    bit          fok;
    bit          fchk;
    bit          err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tx[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         strobe_no = 0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rx_valid === 1'b1 || rx_eof === 1'b1)) begin
      exp_t e;
      vectors++;
      strobe_no++;
      if (rx_valid && rx_eof) begin
        miscompares++;
        $display("FAIL strobe%0d valid_and_eof together", strobe_no);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL strobe%0d unexpected got valid=%0b eof=%0b data=%h len=%0d",
                 strobe_no, rx_valid, rx_eof, rx_data, rx_len);
      end else begin
        e = sb.pop_front();
        if (e.is_eof) begin
          if (!rx_eof || rx_len !== e.len || rx_err !== e.err || (e.fchk && rx_fcs_ok !== e.fok)) begin
            miscompares++;
            $display("FAIL strobe%0d eof got eof=%0b len=%0d err=%0b fcs_ok=%0b exp eof=1 len=%0d err=%0b fcs_ok=%0b(chk=%0b)",
                     strobe_no, rx_eof, rx_len, rx_err, rx_fcs_ok, e.len, e.err, e.fok, e.fchk);
          end
        end else begin
          if (!rx_valid || rx_data !== e.data || rx_sof !== e.sof) begin
            miscompares++;
            $display("FAIL strobe%0d byte got valid=%0b data=%h sof=%0b exp valid=1 data=%h sof=%0b",
                     strobe_no, rx_valid, rx_data, rx_sof, e.data, e.sof);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic build(input int unsigned n, input int unsigned seed);
    tx.delete();
    for (int unsigned i = 0; i < n; i++) tx.push_back(8'((i * 37 + seed * 11 + 5) & 255));
  endtask

  // Bit-serial FCS over the current tx contents, appended LSB byte first
  task automatic add_fcs();
    logic [31:0] c;
    logic [7:0]  b;
    int unsigned n;
    c = 32'hFFFFFFFF;
    n = tx.size();
    for (int unsigned i = 0; i < n; i++) begin
      b = tx[i];
      for (int unsigned k = 0; k < 8; k++) begin
        if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else                       c = c >> 1;
      end
    end
    c = ~c;
    for (int unsigned k = 0; k < 4; k++) tx.push_back(c[8*k +: 8]);
  endtask

  task automatic push_exp(input int unsigned nb, input bit with_eof, input int unsigned len,
                          input bit fok, input bit fchk, input bit err);
    exp_t e;
    for (int unsigned i = 0; i < nb; i++) begin
      e = '{is_eof: 1'b0, data: tx[i], sof: (i == 0), len: '0, fok: 1'b0, fchk: 1'b0, err: 1'b0};
      sb.push_back(e);
    end
    if (with_eof) begin
      e = '{is_eof: 1'b1, data: '0, sof: 1'b0, len: 11'(len), fok: fok, fchk: fchk, err: err};
      sb.push_back(e);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] d, input logic er);
    @(negedge clk);
    eth_crs_dv  = dv;
    eth_rx_data = d;
    eth_rx_err  = er;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic send_preamble();
    for (int unsigned i = 0; i < 31; i++) drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
  endtask

  // toggle: CRS_DV alternates 0/1 over the last 8 dibits, ending high
  task automatic send_bytes(input int unsigned first, input int unsigned n,
                            input int er_byte, input bit toggle);
    logic [7:0]  b;
    logic        dv;
    int unsigned j;
    for (int unsigned i = first; i < n; i++) begin
      b = tx[i];
      for (int unsigned k = 0; k < 4; k++) begin
        j  = i * 4 + k;
        dv = 1'b1;
        if (toggle && j >= 4 * n - 8) dv = ((j - (4 * n - 8)) % 2) == 1;
        drive(dv, b[2*k +: 2], (int'(i) == er_byte) && (k == 0));
      end
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_sof"}, 32'(rx_sof), 32'd0);
    chk({tag, "_eof"}, 32'(rx_eof), 32'd0);
    chk({tag, "_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_len"}, 32'(rx_len), 32'd0);
    chk({tag, "_fcs_ok"}, 32'(rx_fcs_ok), 32'd0);
    chk({tag, "_err"}, 32'(rx_err), 32'd0);
    chk({tag, "_stat_ok"}, 32'(stat_frames_ok), 32'd0);
    chk({tag, "_stat_bad"}, 32'(stat_frames_bad), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    rst_n       = 1'b0;
    eth_crs_dv  = 1'b0;
    eth_rx_data = 2'b00;
    eth_rx_err  = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet_outputs("reset");
    rst_n = 1'b1;
    idle(6);

    // good 64-byte frame
    build(60, 1); add_fcs(); push_exp(64, 1, 64, 1, 1, 0);
    send_preamble(); send_bytes(0, 64, -1, 0); idle(6);
    chk("good_stat_ok", 32'(stat_frames_ok), 32'd1);

    // one payload bit flipped after the FCS was computed
    build(60, 1); add_fcs(); tx[10] = tx[10] ^ 8'h04; push_exp(64, 1, 64, 0, 1, 0);
    send_preamble(); send_bytes(0, 64, -1, 0); idle(6);
    chk("flip_stat_bad", 32'(stat_frames_bad), 32'd1);

    // CRS_DV toggling over the final 8 dibits
    build(60, 2); add_fcs(); push_exp(64, 1, 64, 1, 1, 0);
    send_preamble(); send_bytes(0, 64, -1, 1); idle(6);
    chk("toggle_stat_ok", 32'(stat_frames_ok), 32'd2);

    // PHY error at byte 20
    build(60, 3); add_fcs(); push_exp(64, 1, 64, 1, 1, 1);
    send_preamble(); send_bytes(0, 64, 20, 0); idle(6);

    // false carrier inside the preamble: nothing expected
    drive(1'b1, 2'b01, 1'b0); drive(1'b1, 2'b01, 1'b0); drive(1'b1, 2'b10, 1'b0);
    drive(1'b1, 2'b00, 1'b0); drive(1'b1, 2'b11, 1'b0);
    idle(6);

    // oversize: 1600 bytes, only 1522 delivered, fcs status not predictable
    build(1600, 4); push_exp(1522, 1, 1522, 0, 0, 1);
    send_preamble(); send_bytes(0, 1600, -1, 0); idle(6);

    // 65-byte frame plus two trailing dibits
    build(61, 5); add_fcs(); push_exp(65, 1, 65, 1, 1, 1);
    send_preamble(); send_bytes(0, 65, -1, 0);
    drive(1'b1, 2'b10, 1'b0); drive(1'b1, 2'b01, 1'b0); idle(6);

    // runt: 24 bytes with valid FCS
    build(20, 6); add_fcs(); push_exp(24, 1, 24, 1, 1, 1);
    send_preamble(); send_bytes(0, 24, -1, 0); idle(6);

    chk("stat_ok_total", 32'(stat_frames_ok), 32'd2);
    chk("stat_bad_total", 32'(stat_frames_bad), 32'd5);
    chk("queue_drained_1", 32'(sb.size()), 32'd0);

    // reset mid-frame: 10 bytes out, then reset during byte 10, released with carrier high
    build(60, 7); add_fcs(); push_exp(10, 0, 0, 0, 0, 0);
    send_preamble(); send_bytes(0, 10, -1, 0);
    b = tx[10];
    for (int unsigned k = 0; k < 3; k++) drive(1'b1, b[2*k +: 2], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 2'b01, 1'b0); drive(1'b1, 2'b11, 1'b0);
    check_quiet_outputs("midreset");
    chk("midreset_queue", 32'(sb.size()), 32'd0);
    rst_n = 1'b1;
    send_bytes(11, 64, -1, 0);
    idle(6);
    build(60, 8); add_fcs(); push_exp(64, 1, 64, 1, 1, 0);
    send_preamble(); send_bytes(0, 64, -1, 0); idle(6);
    chk("after_reset_stat_ok", 32'(stat_frames_ok), 32'd1);
    chk("after_reset_stat_bad", 32'(stat_frames_bad), 32'd0);

    idle(10);
    chk("queue_drained_final", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
